// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared memory-bus types, segment map and FSM encoding
package mem_pkg;

  localparam int PHYS_ADDR_WIDTH = 21;

  typedef logic [PHYS_ADDR_WIDTH-1:0] phys_memory_address_t;

  // Loader places code at the bottom of memory and data in the upper half
  localparam phys_memory_address_t CODE_SEGMENT_START = 21'h00_0000;
  localparam phys_memory_address_t DATA_SEGMENT_START = 21'h00_8000;

  typedef enum logic {
    CMD_READ  = 1'b0,
    CMD_WRITE = 1'b1
  } mem_cmd_t;

  // Completion record held while the response waits for the consumer
  typedef struct packed {
    mem_cmd_t cmd;
  } mem_resp_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dram_state_t;

endpackage

// File: rtl/dram_byte_array.sv
// rtl/dram_byte_array.sv - word-organised byte storage with strobed bus port and byte init port
module dram_byte_array #(
  parameter int ADDR_WIDTH = 21,
  parameter int DATA_WIDTH = 64,
  parameter int MEM_BYTES  = 65536
) (
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic [DATA_WIDTH-1:0]   rdata,
  input  logic                    init_we,
  input  logic [ADDR_WIDTH-1:0]   init_addr,
  input  logic [7:0]              init_data
);

  localparam int LANES  = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(LANES);
  localparam int WORDS  = MEM_BYTES / LANES;
  localparam int WORD_W = $clog2(WORDS);

  // Storage is deliberately not reset so contents survive rst_n
  logic [DATA_WIDTH-1:0] words [WORDS];

  logic [WORD_W-1:0] word_idx;
  logic [WORD_W-1:0] init_word;
  logic [OFF_W-1:0]  init_lane;

  // Dropping the low offset bits aligns down; truncating the high bits wraps
  assign word_idx  = WORD_W'(addr >> OFF_W);
  assign init_word = WORD_W'(init_addr >> OFF_W);
  assign init_lane = OFF_W'(init_addr);

  assign rdata = words[word_idx];

  // Bus lanes first, init byte last so the init write wins on a collision
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < LANES; k++) begin
        if (wstrb[k]) begin
          words[word_idx][8*k +: 8] <= wdata[8*k +: 8];
        end
      end
    end
    if (init_we) begin
      words[init_word][{init_lane, 3'b000} +: 8] <= init_data;
    end
  end

endmodule

// File: rtl/dram_model.sv
// rtl/dram_model.sv - single-request main memory with fixed read/write latency
module dram_model
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH    = 21,
  parameter int DATA_WIDTH    = 64,
  parameter int MEM_BYTES     = 65536,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic                    resp_write,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  input  logic                    init_we,
  input  logic [ADDR_WIDTH-1:0]   init_addr,
  input  logic [7:0]              init_data
);

  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LATENCY - 1);

  dram_state_t             state_q;
  dram_state_t             state_d;
  logic [CNT_W-1:0]        cnt_q;
  logic                    lat_write_q;
  logic [ADDR_WIDTH-1:0]   lat_addr_q;
  mem_resp_t               resp_q;
  logic [DATA_WIDTH-1:0]   rdata_q;

  logic                    accept;
  logic                    bus_wr;
  logic [ADDR_WIDTH-1:0]   arr_addr;
  logic [DATA_WIDTH-1:0]   arr_rdata;

  assign accept = req_valid && req_ready;
  assign bus_wr = accept && req_write;

  // The single array port serves the incoming write in IDLE and the pending read afterwards
  assign arr_addr = (state_q == ST_IDLE) ? req_addr : lat_addr_q;

  dram_byte_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_BYTES  (MEM_BYTES)
  ) u_array (
    .clk       (clk),
    .wr_en     (bus_wr),
    .addr      (arr_addr),
    .wdata     (req_wdata),
    .wstrb     (req_wstrb),
    .rdata     (arr_rdata),
    .init_we   (init_we),
    .init_addr (init_addr),
    .init_data (init_data)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: accept, count down, then hold until the consumer takes the response
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_valid)      state_d = ST_WAIT;
      ST_WAIT: if (cnt_q == '0)    state_d = ST_RESP;
      ST_RESP: if (resp_ready)     state_d = ST_IDLE;
      default:                     state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decode directly from the registered state
  always_comb begin
    req_ready  = (state_q == ST_IDLE);
    resp_valid = (state_q == ST_RESP);
    resp_write = (resp_q.cmd == CMD_WRITE);
    resp_rdata = rdata_q;
  end

  // Request latch, latency countdown and response capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      lat_write_q <= 1'b0;
      lat_addr_q  <= '0;
      resp_q.cmd  <= CMD_READ;
      rdata_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            lat_write_q <= req_write;
            lat_addr_q  <= req_addr;
            cnt_q       <= req_write ? WR_LOAD : RD_LOAD;
          end
        end
        ST_WAIT: begin
          if (cnt_q == '0) begin
            resp_q.cmd <= lat_write_q ? CMD_WRITE : CMD_READ;
            rdata_q    <= lat_write_q ? '0 : arr_rdata;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_q.cmd <= CMD_READ;
            rdata_q    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_model.sv
// tb/tb_dram_model.sv - self-checking bench for dram_model against a transaction-level memory model
module tb_dram_model;

  localparam int AW  = 21;
  localparam int DW  = 64;
  localparam int MEM = 65536;
  localparam int RL  = 4;
  localparam int WL  = 4;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [7:0]    req_wstrb;
  logic          resp_valid;
  logic          resp_ready;
  logic          resp_write;
  logic [DW-1:0] resp_rdata;
  logic          init_we;
  logic [AW-1:0] init_addr;
  logic [7:0]    init_data;

  int tests_run    = 0;
  int tests_failed = 0;

  dram_model #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .MEM_BYTES     (MEM),
    .READ_LATENCY  (RL),
    .WRITE_LATENCY (WL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_write (resp_write),
    .resp_rdata (resp_rdata),
    .init_we    (init_we),
    .init_addr  (init_addr),
    .init_data  (init_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model: byte memory plus one outstanding transaction
  bit [7:0]    mem_m [MEM];
  bit          m_busy;
  bit          m_shown;
  bit          m_write;
  logic [AW-1:0] m_addr;
  int          m_due;
  int          edge_no;
  logic [63:0] m_rdata;
  bit          m_rwrite;

  function automatic logic [63:0] model_word(input logic [AW-1:0] a);
    logic [63:0] w;
    int base;
    base = (int'(a) % MEM) & ~7;
    for (int k = 0; k < 8; k++) w[8*k +: 8] = mem_m[base + k];
    return w;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  = 1'b0;
      m_shown = 1'b0;
    end else begin
      edge_no++;
      if (m_busy) begin
        if (m_shown) begin
          if (resp_ready) begin
            m_shown = 1'b0;
            m_busy  = 1'b0;
          end
        end else if (edge_no == m_due) begin
          m_shown  = 1'b1;
          m_rwrite = m_write;
          m_rdata  = m_write ? 64'd0 : model_word(m_addr);
        end
      end else if (req_valid) begin
        m_busy  = 1'b1;
        m_write = req_write;
        m_addr  = req_addr;
        m_due   = edge_no + (req_write ? WL : RL);
        if (req_write) begin
          for (int k = 0; k < 8; k++)
            if (req_wstrb[k]) mem_m[((int'(req_addr) % MEM) & ~7) + k] = req_wdata[8*k +: 8];
        end
      end
      if (init_we) mem_m[int'(init_addr) % MEM] = init_data;
    end
  end

  // Every cycle: handshake and response contents against the model
  always @(negedge clk) begin
    chk("req_ready", {63'd0, req_ready}, {63'd0, !m_busy});
    chk("resp_valid", {63'd0, resp_valid}, {63'd0, m_shown});
    if (m_shown && resp_valid) begin
      chk("resp_write", {63'd0, resp_write}, {63'd0, m_rwrite});
      chk("resp_rdata", resp_rdata, m_rdata);
    end
  end

  // ---------------- stimulus helpers (all called just after a rising edge)
  task automatic init_byte(input logic [AW-1:0] a, input logic [7:0] d);
    init_we   = 1'b1;
    init_addr = a;
    init_data = d;
    @(posedge clk); #1;
    init_we = 1'b0;
  endtask

  task automatic wait_resp(input int hold, output logic [63:0] rd, output bit rw, output int lat);
    lat = 0;
    while (!resp_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!resp_valid) begin
      tests_run++;
      tests_failed++;
      $display("FAIL resp_timeout: got no resp_valid expected one within 100 cycles");
      rd = '0;
      rw = 1'b0;
    end else begin
      repeat (hold) begin @(posedge clk); #1; end
      rd = resp_rdata;
      rw = resp_write;
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
    end
  endtask

  task automatic wait_ready();
    int guard;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!req_ready) begin
      tests_run++;
      tests_failed++;
      $display("FAIL ready_timeout: got req_ready=0 expected 1 within 50 cycles");
    end
  endtask

  task automatic do_req(input bit wr, input logic [AW-1:0] a, input logic [63:0] wd,
                        input logic [7:0] ws, input int hold,
                        output logic [63:0] rd, output bit rw, output int lat);
    wait_ready();
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = wd;
    req_wstrb = ws;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_resp(hold, rd, rw, lat);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got still running expected finished");
    tests_failed++;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    logic [63:0] rd;
    bit          rw;
    int          lat;
    int          seen;
    logic [AW-1:0] ra;

    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_wstrb = '0; resp_ready = 1'b0;
    init_we = 1'b0; init_addr = '0; init_data = '0;

    repeat (2) @(posedge clk); #1;
    chk("reset_req_ready", {63'd0, req_ready}, 64'd1);
    chk("reset_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("reset_resp_write", {63'd0, resp_write}, 64'd0);
    chk("reset_resp_rdata", resp_rdata, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Known contents for the window the random phase touches
    for (int a = 0; a < 1024; a++) init_byte(AW'(a), 8'($urandom));

    // Init-port preload then aligned read
    for (int i = 0; i < 8; i++) init_byte(AW'(32'h100 + i), 8'(8'h11 * (i + 1)));
    do_req(1'b0, 21'h100, '0, '0, 0, rd, rw, lat);
    chk("init_read_lat", 64'(lat), 64'd4);
    chk("init_read_data", rd, 64'h8877665544332211);
    chk("init_read_wflag", {63'd0, rw}, 64'd0);

    // Strobed write of the low half
    do_req(1'b1, 21'h100, 64'hDEADBEEFCAFEF00D, 8'h0F, 0, rd, rw, lat);
    chk("write_ack_lat", 64'(lat), 64'd4);
    chk("write_ack_data", rd, 64'd0);
    chk("write_ack_wflag", {63'd0, rw}, 64'd1);
    do_req(1'b0, 21'h100, '0, '0, 0, rd, rw, lat);
    chk("strobe_read", rd, 64'h88776655CAFEF00D);

    // Unaligned address and wrap-around aliasing
    do_req(1'b0, 21'h103, '0, '0, 0, rd, rw, lat);
    chk("unaligned_read", rd, 64'h88776655CAFEF00D);
    do_req(1'b0, AW'(32'h100 + MEM), '0, '0, 0, rd, rw, lat);
    chk("alias_read", rd, 64'h88776655CAFEF00D);

    // Back-pressure: response held, request pulse ignored, next request one cycle after handshake
    wait_ready();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 21'h100;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    chk("hold_lat", 64'(lat), 64'd4);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", {63'd0, resp_valid}, 64'd1);
      chk("hold_data", resp_rdata, 64'h88776655CAFEF00D);
      chk("hold_ready_low", {63'd0, req_ready}, 64'd0);
      if (i == 1) begin req_valid = 1'b1; req_addr = 21'h103; end
      if (i == 2) req_valid = 1'b0;
      @(posedge clk); #1;
    end
    req_valid = 1'b1; req_addr = 21'h108; resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("handshake_no_accept", {63'd0, req_ready}, 64'd1);
    chk("handshake_valid_drop", {63'd0, resp_valid}, 64'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("accept_after_handshake", {63'd0, req_ready}, 64'd0);
    wait_resp(0, rd, rw, lat);
    chk("post_hold_lat", 64'(lat), 64'd4);

    // Reset two cycles into a read drops it; storage survives
    wait_ready();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 21'h100;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    chk("midreset_ready", {63'd0, req_ready}, 64'd1);
    chk("midreset_valid", {63'd0, resp_valid}, 64'd0);
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin @(posedge clk); #1; if (resp_valid) seen++; end
    chk("no_resp_after_reset", 64'(seen), 64'd0);
    do_req(1'b0, 21'h100, '0, '0, 0, rd, rw, lat);
    chk("retained_after_reset", rd, 64'h88776655CAFEF00D);

    // Init write beats a bus write to the same byte on the same edge
    wait_ready();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 21'h200;
    req_wdata = 64'hAA; req_wstrb = 8'h01;
    init_we = 1'b1; init_addr = 21'h200; init_data = 8'h55;
    @(posedge clk); #1;
    req_valid = 1'b0; init_we = 1'b0;
    wait_resp(0, rd, rw, lat);
    do_req(1'b0, 21'h200, '0, '0, 0, rd, rw, lat);
    chk("collision_byte0", 64'(rd[7:0]), 64'h55);

    // Randomised traffic over the preloaded window with wrapping high bits
    for (int t = 0; t < 200; t++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        if ($urandom_range(0, 1) == 1)
          init_byte(AW'($urandom_range(0, 1023)) | (AW'($urandom_range(0, 31)) << 16), 8'($urandom));
        else begin
          @(posedge clk); #1;
        end
      end
      ra = AW'($urandom_range(0, 1023)) | (AW'($urandom_range(0, 31)) << 16);
      do_req($urandom_range(0, 1) == 1, ra, {$urandom, $urandom}, 8'($urandom),
             $urandom_range(0, 3), rd, rw, lat);
      chk("rand_latency", 64'(lat), rw ? 64'(WL) : 64'(RL));
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
